// File: rtl/cp1_issue_ctrl.sv
// CP1 issue/sequencing controller: single in-flight arithmetic op, hazard stalls and mfc1/mtc1 strobes.
// Optional performance counters are built when CP1_PERF_CNT_EN is defined.
module cp1_issue_ctrl #(
  parameter int LAT_ADD = 2,
  parameter int LAT_MUL = 3,
  parameter int LAT_DIV = 8,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic [31:0] issue_inst,
  output logic        issue_ready,
  output logic [31:0] fpu_inst,
  output logic        fpu_start,
  output logic        wb_en,
  output logic [4:0]  wb_reg,
  output logic        mv_we,
  output logic        mv_re,
  output logic [4:0]  mv_reg
`ifdef CP1_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_op_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LAT_ADD_M1 = CNT_W'(LAT_ADD - 1);
  localparam logic [CNT_W-1:0] LAT_MUL_M1 = CNT_W'(LAT_MUL - 1);
  localparam logic [CNT_W-1:0] LAT_DIV_M1 = CNT_W'(LAT_DIV - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        busy_rd_q, busy_rd_d;
  logic [31:0]       fpu_inst_q, fpu_inst_d;
  logic              fpu_start_q, fpu_start_d;
  logic              wb_en_q, wb_en_d;
  logic [4:0]        wb_reg_q, wb_reg_d;
  logic              mv_we_q, mv_we_d;
  logic              mv_re_q, mv_re_d;
  logic [4:0]        mv_reg_q, mv_reg_d;

  // Instruction decode
  logic              dec_cop1;
  logic              dec_arith;
  logic              dec_mfc1;
  logic              dec_mtc1;
  logic [4:0]        dec_fs;
  logic [4:0]        dec_fd;
  logic [CNT_W-1:0]  dec_lat_m1;

  always_comb begin
    dec_cop1  = (issue_inst[31:26] == 6'b010001);
    dec_arith = dec_cop1 && (issue_inst[25:21] == 5'b10000) && (issue_inst[5:2] == 4'b0000);
    dec_mfc1  = dec_cop1 && (issue_inst[25:21] == 5'b00000);
    dec_mtc1  = dec_cop1 && (issue_inst[25:21] == 5'b00100);
    dec_fs    = issue_inst[15:11];
    dec_fd    = issue_inst[10:6];
    dec_lat_m1 = LAT_ADD_M1;
    case (issue_inst[1:0])
      2'd0, 2'd1: dec_lat_m1 = LAT_ADD_M1;
      2'd2:       dec_lat_m1 = LAT_MUL_M1;
      2'd3:       dec_lat_m1 = LAT_DIV_M1;
      default:    dec_lat_m1 = LAT_ADD_M1;
    endcase
  end

  // Hazard detection. Moves read/write the register file directly, so no
  // forwarding from the in-flight op; an mtc1 accepted at cnt==0 would land
  // its write in the same cycle as wb_en.
  logic in_flight;
  logic hit_busy;
  logic stall;
  logic accept;
  logic acc_arith;
  logic acc_mfc1;
  logic acc_mtc1;

  always_comb begin
    in_flight = (state_q == S_EXEC) || (state_q == S_WB);
    hit_busy  = in_flight && (dec_fs == busy_rd_q);
    stall     = (dec_arith && (state_q == S_EXEC))
             || (dec_mfc1 && hit_busy)
             || (dec_mtc1 && hit_busy)
             || (dec_mtc1 && (state_q == S_EXEC) && (cnt_q == '0));
    issue_ready = !rst && !stall;
    accept    = issue_valid && issue_ready;
    acc_arith = accept && dec_arith;
    acc_mfc1  = accept && dec_mfc1;
    acc_mtc1  = accept && dec_mtc1;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_rd_d   = busy_rd_q;
    fpu_inst_d  = fpu_inst_q;
    fpu_start_d = 1'b0;
    wb_en_d     = 1'b0;
    wb_reg_d    = wb_reg_q;
    mv_we_d     = acc_mtc1;
    mv_re_d     = acc_mfc1;
    mv_reg_d    = (acc_mtc1 || acc_mfc1) ? dec_fs : mv_reg_q;

    case (state_q)
      S_IDLE, S_WB: begin
        if (acc_arith) begin
          state_d     = S_EXEC;
          cnt_d       = dec_lat_m1;
          busy_rd_d   = dec_fd;
          fpu_inst_d  = issue_inst;
          fpu_start_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        if (cnt_q == '0) begin
          state_d  = S_WB;
          wb_en_d  = 1'b1;
          wb_reg_d = busy_rd_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      busy_rd_q   <= '0;
      fpu_inst_q  <= '0;
      fpu_start_q <= 1'b0;
      wb_en_q     <= 1'b0;
      wb_reg_q    <= '0;
      mv_we_q     <= 1'b0;
      mv_re_q     <= 1'b0;
      mv_reg_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_rd_q   <= busy_rd_d;
      fpu_inst_q  <= fpu_inst_d;
      fpu_start_q <= fpu_start_d;
      wb_en_q     <= wb_en_d;
      wb_reg_q    <= wb_reg_d;
      mv_we_q     <= mv_we_d;
      mv_re_q     <= mv_re_d;
      mv_reg_q    <= mv_reg_d;
    end
  end

  assign fpu_inst  = fpu_inst_q;
  assign fpu_start = fpu_start_q;
  assign wb_en     = wb_en_q;
  assign wb_reg    = wb_reg_q;
  assign mv_we     = mv_we_q;
  assign mv_re     = mv_re_q;
  assign mv_reg    = mv_reg_q;

`ifdef CP1_PERF_CNT_EN
  // Saturating counters: stalled request cycles and accepted operations.
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] op_cnt_q, op_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    op_cnt_d    = op_cnt_q;
    if (issue_valid && !issue_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if ((acc_arith || acc_mfc1 || acc_mtc1) && (op_cnt_q != 32'hFFFF_FFFF)) begin
      op_cnt_d = op_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      op_cnt_q    <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      op_cnt_q    <= op_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_op_cnt    = op_cnt_q;
`endif

endmodule

// File: tb/tb_cp1_issue_ctrl.sv
// Scoreboard bench for cp1_issue_ctrl: stimulus pushes expected output events, a negedge monitor pops and compares.
module tb_cp1_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic [31:0] issue_inst = 32'd0;
  logic        issue_ready;
  logic [31:0] fpu_inst;
  logic        fpu_start;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic        mv_we;
  logic        mv_re;
  logic [4:0]  mv_reg;
`ifdef CP1_PERF_CNT_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_op_cnt;
`endif

  cp1_issue_ctrl #(.LAT_ADD(2), .LAT_MUL(3), .LAT_DIV(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_inst(issue_inst),
    .issue_ready(issue_ready), .fpu_inst(fpu_inst), .fpu_start(fpu_start),
    .wb_en(wb_en), .wb_reg(wb_reg), .mv_we(mv_we), .mv_re(mv_re), .mv_reg(mv_reg)
`ifdef CP1_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_op_cnt(perf_op_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    int          kind;
  } ev_t;

  ev_t q_start[$];
  ev_t q_wb[$];
  ev_t q_mv[$];
  int  cyc = 0;
  int  n_checks = 0;
  int  n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] f_arith(input logic [5:0] funct, input logic [4:0] fd,
                                          input logic [4:0] fs, input logic [4:0] ft);
    return {6'b010001, 5'b10000, ft, fs, fd, funct};
  endfunction

  function automatic logic [31:0] f_mfc1(input logic [4:0] fs);
    return {6'b010001, 5'b00000, 5'd2, fs, 11'd0};
  endfunction

  function automatic logic [31:0] f_mtc1(input logic [4:0] fs);
    return {6'b010001, 5'b00100, 5'd2, fs, 11'd0};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic push_start(input int c, input logic [31:0] inst);
    q_start.push_back('{cyc: c, data: inst, kind: 0});
  endtask

  task automatic push_wb(input int c, input logic [4:0] r);
    q_wb.push_back('{cyc: c, data: {27'd0, r}, kind: 0});
  endtask

  // kind 0 = mv_re (mfc1), 1 = mv_we (mtc1)
  task automatic push_mv(input int c, input logic [4:0] r, input int k);
    q_mv.push_back('{cyc: c, data: {27'd0, r}, kind: k});
  endtask

  // Present one instruction until accepted; acc is the cycle that starts at the accepting edge.
  task automatic send(input logic [31:0] inst, input int exp_stall, input string nm, output int acc);
    int stalls;
    stalls = 0;
    @(negedge clk);
    issue_valid = 1'b1;
    issue_inst  = inst;
    #1;
    while (!issue_ready && stalls < 40) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    acc = cyc + 1;
    n_checks++;
    if (!issue_ready) begin
      n_errors++;
      $display("FAIL %s_timeout: never accepted after %0d stall cycles, expected %0d", nm, stalls, exp_stall);
      issue_valid = 1'b0;
      acc = -100;
      return;
    end
    if (stalls != exp_stall) begin
      n_errors++;
      $display("FAIL %s_stall: got %0d stall cycles, expected %0d", nm, stalls, exp_stall);
    end
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    issue_inst  = 32'd0;
    $display("issue %-10s inst=%h stalls=%0d accept_cycle=%0d", nm, inst, stalls, acc);
  endtask

  // Monitor: every output pulse must match the head of its expectation queue.
  always @(negedge clk) begin
    ev_t e;
    if (fpu_start === 1'b1) begin
      n_checks++;
      if (q_start.size() == 0) begin
        n_errors++;
        $display("FAIL start_unexpected: cycle %0d fpu_inst=%h, none expected", cyc, fpu_inst);
      end else begin
        e = q_start.pop_front();
        if (e.cyc != cyc || e.data !== fpu_inst) begin
          n_errors++;
          $display("FAIL start: cycle %0d inst %h, expected cycle %0d inst %h", cyc, fpu_inst, e.cyc, e.data);
        end
      end
    end
    if (wb_en === 1'b1) begin
      n_checks++;
      if (q_wb.size() == 0) begin
        n_errors++;
        $display("FAIL wb_unexpected: cycle %0d wb_reg=%0d, none expected", cyc, wb_reg);
      end else begin
        e = q_wb.pop_front();
        if (e.cyc != cyc || e.data[4:0] !== wb_reg) begin
          n_errors++;
          $display("FAIL wb: cycle %0d reg %0d, expected cycle %0d reg %0d", cyc, wb_reg, e.cyc, e.data[4:0]);
        end
      end
    end
    if (mv_we === 1'b1 || mv_re === 1'b1) begin
      n_checks++;
      if (q_mv.size() == 0) begin
        n_errors++;
        $display("FAIL mv_unexpected: cycle %0d we=%b re=%b reg=%0d, none expected", cyc, mv_we, mv_re, mv_reg);
      end else begin
        e = q_mv.pop_front();
        if (e.cyc != cyc || e.data[4:0] !== mv_reg || mv_we !== (e.kind == 1) || mv_re !== (e.kind == 0)) begin
          n_errors++;
          $display("FAIL mv: cycle %0d we=%b re=%b reg %0d, expected cycle %0d kind %0d reg %0d",
                   cyc, mv_we, mv_re, mv_reg, e.cyc, e.kind, e.data[4:0]);
        end
      end
    end
    if (mv_we === 1'b1) begin
      n_checks++;
      if (wb_en === 1'b1) begin
        n_errors++;
        $display("FAIL port_collision: cycle %0d mv_we=1 wb_en=1, expected not both", cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int a1;
    int ad;
    int am;
    int aa;

    // Reset state; a valid request during reset must not be accepted
    rst = 1'b1;
    issue_valid = 1'b1;
    issue_inst = f_arith(6'd0, 5'd3, 5'd1, 5'd2);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", {63'd0, issue_ready}, 64'd0);
    chk("rst_outs", {18'd0, fpu_inst, fpu_start, wb_en, mv_we, mv_re, wb_reg, mv_reg}, 64'd0);
    issue_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Test 1: add.s f3, start next cycle, wb two cycles later
    send(f_arith(6'd0, 5'd3, 5'd1, 5'd2), 0, "add.s_f3", a1);
    push_start(a1, f_arith(6'd0, 5'd3, 5'd1, 5'd2));
    push_wb(a1 + 2, 5'd3);

    // Test 2: div.s right behind it is accepted in the add's WB cycle; mul.s waits out the div
    send(f_arith(6'd3, 5'd5, 5'd1, 5'd2), 2, "div.s_f5", ad);
    push_start(ad, f_arith(6'd3, 5'd5, 5'd1, 5'd2));
    push_wb(ad + 8, 5'd5);
    send(f_arith(6'd2, 5'd6, 5'd1, 5'd2), 8, "mul.s_f6", a);
    push_start(ad + 9, f_arith(6'd2, 5'd6, 5'd1, 5'd2));
    push_wb(ad + 12, 5'd6);
    repeat (5) @(negedge clk);

    // Test 3: mfc1 of an unrelated reg passes, mfc1 of the busy reg waits past WB
    send(f_arith(6'd2, 5'd7, 5'd1, 5'd2), 0, "mul.s_f7", am);
    push_start(am, f_arith(6'd2, 5'd7, 5'd1, 5'd2));
    push_wb(am + 3, 5'd7);
    send(f_mfc1(5'd4), 0, "mfc1_f4", a);
    push_mv(am + 1, 5'd4, 0);
    send(f_mfc1(5'd7), 3, "mfc1_f7", a);
    push_mv(am + 5, 5'd7, 0);
    repeat (3) @(negedge clk);

    // Test 4: mtc1 ok at cnt==1, blocked at cnt==0, ok in WB for another reg
    send(f_arith(6'd0, 5'd10, 5'd1, 5'd2), 0, "add.s_f10", aa);
    push_start(aa, f_arith(6'd0, 5'd10, 5'd1, 5'd2));
    push_wb(aa + 2, 5'd10);
    send(f_mtc1(5'd9), 0, "mtc1_f9a", a);
    push_mv(aa + 1, 5'd9, 1);
    send(f_mtc1(5'd9), 1, "mtc1_f9b", a);
    push_mv(aa + 3, 5'd9, 1);
    // WAW: mtc1 to the busy register waits until IDLE
    send(f_arith(6'd1, 5'd12, 5'd1, 5'd2), 0, "sub.s_f12", aa);
    push_start(aa, f_arith(6'd1, 5'd12, 5'd1, 5'd2));
    push_wb(aa + 2, 5'd12);
    send(f_mtc1(5'd12), 3, "mtc1_f12", a);
    push_mv(aa + 4, 5'd12, 1);
    // Non-arith encodings are accepted with no action even while EXEC is busy
    send(f_arith(6'd0, 5'd13, 5'd1, 5'd2), 0, "add.s_f13", aa);
    push_start(aa, f_arith(6'd0, 5'd13, 5'd1, 5'd2));
    push_wb(aa + 2, 5'd13);
    send(32'h0000_0020, 0, "non_cop1", a);
    send(f_arith(6'd4, 5'd14, 5'd1, 5'd2), 0, "funct4", a);
    send({6'b010001, 5'b10001, 5'd2, 5'd1, 5'd15, 6'd0}, 0, "fmt_d", a);
    repeat (4) @(negedge clk);

    // Test 5: reset in the third div.s EXEC cycle drops the op
    send(f_arith(6'd3, 5'd5, 5'd1, 5'd2), 0, "div.s_rst", ad);
    push_start(ad, f_arith(6'd3, 5'd5, 5'd1, 5'd2));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    issue_valid = 1'b1;
    issue_inst = f_arith(6'd0, 5'd3, 5'd1, 5'd2);
    @(negedge clk);
    #1;
    chk("mid_rst_ready", {63'd0, issue_ready}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_outs", {18'd0, fpu_inst, fpu_start, wb_en, mv_we, mv_re, wb_reg, mv_reg}, 64'd0);
    repeat (12) @(negedge clk);
    send(f_arith(6'd0, 5'd3, 5'd1, 5'd2), 0, "add.s_after", a);
    push_start(a, f_arith(6'd0, 5'd3, 5'd1, 5'd2));
    push_wb(a + 2, 5'd3);
    repeat (4) @(negedge clk);

`ifdef CP1_PERF_CNT_EN
    // Test 6: counters over the div/mul stall sequence
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("perf_rst", {perf_stall_cnt, perf_op_cnt}, 64'd0);
    send(f_arith(6'd3, 5'd5, 5'd1, 5'd2), 0, "div.s_perf", ad);
    push_start(ad, f_arith(6'd3, 5'd5, 5'd1, 5'd2));
    push_wb(ad + 8, 5'd5);
    send(f_arith(6'd2, 5'd6, 5'd1, 5'd2), 8, "mul.s_perf", a);
    push_start(ad + 9, f_arith(6'd2, 5'd6, 5'd1, 5'd2));
    push_wb(ad + 12, 5'd6);
    repeat (4) @(negedge clk);
    chk("perf_stall", {32'd0, perf_stall_cnt}, 64'd8);
    chk("perf_op", {32'd0, perf_op_cnt}, 64'd2);
    send(32'h0000_0020, 0, "non_cop1_p", a);
    @(negedge clk);
    chk("perf_nop", {perf_stall_cnt, perf_op_cnt}, {32'd8, 32'd2});
    send(f_mfc1(5'd1), 0, "mfc1_perf", a);
    push_mv(a, 5'd1, 0);
    @(negedge clk);
    chk("perf_op_mv", {32'd0, perf_op_cnt}, 64'd3);
    repeat (2) @(negedge clk);
`endif

    chk("q_start_empty", 64'(q_start.size()), 64'd0);
    chk("q_wb_empty", 64'(q_wb.size()), 64'd0);
    chk("q_mv_empty", 64'(q_mv.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
